// File: rtl/cpu_defines.sv
// Shared encodings for the ID-stage branch sequencer: branch classes,
// sequencer states, hazard classes and source-use helpers.
package cpu_defines;

  // Nine branch classes do not fit in three bits, so the op field is four wide.
  localparam int BR_OP_W = 4;

  typedef enum logic [3:0] {
    BR_NONE = 4'd0,
    BR_BEQ  = 4'd1,
    BR_BNE  = 4'd2,
    BR_BLEZ = 4'd3,
    BR_BGTZ = 4'd4,
    BR_BLTZ = 4'd5,
    BR_BGEZ = 4'd6,
    BR_J    = 4'd7,
    BR_JR   = 4'd8
  } br_op_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WAIT2 = 2'd1,
    ST_WAIT1 = 2'd2
  } br_state_t;

  typedef enum logic [1:0] {
    HZ_NONE     = 2'd0,
    HZ_LOAD_EX  = 2'd1,
    HZ_EX       = 2'd2,
    HZ_LOAD_MEM = 2'd3
  } hz_class_t;

  localparam logic [31:0] INIT_32 = 32'h0000_0000;

  function automatic logic is_branch(input logic [BR_OP_W-1:0] op);
    return (op >= 4'd1) && (op <= 4'd8);
  endfunction

  function automatic logic uses_rs(input logic [BR_OP_W-1:0] op);
    return ((op >= 4'd1) && (op <= 4'd6)) || (op == 4'd8);
  endfunction

  function automatic logic uses_rt(input logic [BR_OP_W-1:0] op);
    return (op == 4'd1) || (op == 4'd2);
  endfunction

endpackage

// File: rtl/br_hazard_det.sv
// Combinational hazard classifier: compares the used ID sources against the
// EX and MEM destinations and returns the highest-priority hazard class.
module br_hazard_det
  import cpu_defines::*;
(
  input  logic       use_rs,
  input  logic       use_rt,
  input  logic [4:0] rs,
  input  logic [4:0] rt,
  input  logic       ex_wr_en,
  input  logic [4:0] ex_wr_reg,
  input  logic       ex_is_load,
  input  logic [4:0] mem_wr_reg,
  input  logic       mem_is_load,
  output hz_class_t  hz
);

  logic rs_live;
  logic rt_live;
  logic ex_hit;
  logic mem_hit;

  // Register 0 is hardwired, so it never creates a dependency.
  always_comb begin
    rs_live = use_rs && (rs != 5'd0);
    rt_live = use_rt && (rt != 5'd0);
    ex_hit  = ex_wr_en && ((rs_live && (rs == ex_wr_reg)) || (rt_live && (rt == ex_wr_reg)));
    mem_hit = mem_is_load && ((rs_live && (rs == mem_wr_reg)) || (rt_live && (rt == mem_wr_reg)));
    if (ex_hit && ex_is_load) begin
      hz = HZ_LOAD_EX;
    end else if (ex_hit) begin
      hz = HZ_EX;
    end else if (mem_hit) begin
      hz = HZ_LOAD_MEM;
    end else begin
      hz = HZ_NONE;
    end
  end

endmodule

// File: rtl/branch_ctrl.sv
// ID-stage branch/jump sequencer: stalls on unforwardable operands, resolves
// the branch and issues a one-cycle registered PC redirect with IF/ID flush.
module branch_ctrl
  import cpu_defines::*;
#(
  parameter int PC_W  = 32,
  parameter int CNT_W = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               id_valid,
  input  logic [BR_OP_W-1:0] id_br_op,
  input  logic [4:0]         id_rs,
  input  logic [4:0]         id_rt,
  input  logic [31:0]        rs_data,
  input  logic [31:0]        rt_data,
  input  logic [PC_W-1:0]    id_pc,
  input  logic [15:0]        id_imm,
  input  logic [25:0]        id_jidx,
  input  logic               ex_wr_en,
  input  logic [4:0]         ex_wr_reg,
  input  logic               ex_is_load,
  input  logic [4:0]         mem_wr_reg,
  input  logic               mem_is_load,
  output logic               stall_id,
  output logic               flush_if_id,
  output logic               redirect_valid,
  output logic [PC_W-1:0]    redirect_pc,
  output logic [CNT_W-1:0]   br_cnt,
  output logic [CNT_W-1:0]   taken_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  br_state_t        state;
  br_state_t        next_state;
  hz_class_t        hz;
  logic             is_br;
  logic             hazard;
  logic             resolve;
  logic             taken;
  logic [PC_W-1:0]  pc4;
  logic [PC_W-1:0]  target;
  logic signed [31:0] rs_s;

  br_hazard_det u_hz (
    .use_rs      (uses_rs(id_br_op)),
    .use_rt      (uses_rt(id_br_op)),
    .rs          (id_rs),
    .rt          (id_rt),
    .ex_wr_en    (ex_wr_en),
    .ex_wr_reg   (ex_wr_reg),
    .ex_is_load  (ex_is_load),
    .mem_wr_reg  (mem_wr_reg),
    .mem_is_load (mem_is_load),
    .hz          (hz)
  );

  assign is_br  = id_valid && is_branch(id_br_op);
  assign hazard = (hz != HZ_NONE);

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next state: a load in EX needs two wait states, other hazards one.
  always_comb begin
    next_state = ST_IDLE;
    case (state)
      ST_IDLE: begin
        if (is_br && (hz == HZ_LOAD_EX)) begin
          next_state = ST_WAIT2;
        end else if (is_br && hazard) begin
          next_state = ST_WAIT1;
        end else begin
          next_state = ST_IDLE;
        end
      end
      ST_WAIT2: next_state = ST_WAIT1;
      ST_WAIT1: next_state = ST_IDLE;
      default:  next_state = ST_IDLE;
    endcase
  end

  // FSM outputs: stall while waiting or while a fresh hazard is seen in IDLE.
  always_comb begin
    stall_id = 1'b0;
    resolve  = 1'b0;
    if (state != ST_IDLE) begin
      stall_id = 1'b1;
    end else begin
      stall_id = is_br && hazard;
      resolve  = is_br && !hazard;
    end
  end

  // Signed compare and target select.
  always_comb begin
    rs_s  = $signed(rs_data);
    pc4   = id_pc + PC_W'(4);
    taken = 1'b0;
    target = pc4 + {{(PC_W-18){id_imm[15]}}, id_imm, 2'b00};
    case (id_br_op)
      BR_BEQ:  taken = (rs_data == rt_data);
      BR_BNE:  taken = (rs_data != rt_data);
      BR_BLEZ: taken = (rs_s <= 32'sd0);
      BR_BGTZ: taken = (rs_s > 32'sd0);
      BR_BLTZ: taken = (rs_s < 32'sd0);
      BR_BGEZ: taken = (rs_s >= 32'sd0);
      BR_J: begin
        taken  = 1'b1;
        target = {pc4[PC_W-1:28], id_jidx, 2'b00};
      end
      BR_JR: begin
        taken  = 1'b1;
        target = PC_W'(rs_data);
      end
      default: taken = 1'b0;
    endcase
  end

  // Redirect pulse and saturating performance counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      redirect_valid <= 1'b0;
      flush_if_id    <= 1'b0;
      redirect_pc    <= PC_W'(INIT_32);
      br_cnt         <= CNT_W'(INIT_32);
      taken_cnt      <= CNT_W'(INIT_32);
    end else begin
      redirect_valid <= resolve && taken;
      flush_if_id    <= resolve && taken;
      redirect_pc    <= (resolve && taken) ? target : PC_W'(INIT_32);
      if (resolve && (br_cnt != CNT_MAX)) begin
        br_cnt <= br_cnt + CNT_W'(1);
      end
      if (resolve && taken && (taken_cnt != CNT_MAX)) begin
        taken_cnt <= taken_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_branch_ctrl.sv
// Self-checking bench for branch_ctrl: directed scenarios plus a randomized
// run against a cycle-count reference model; counters are 4 bits wide.
module tb_branch_ctrl;

  localparam int PC_W  = 32;
  localparam int CNT_W = 4;
  localparam int CMAX  = 15;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             id_valid;
  logic [3:0]       id_br_op;
  logic [4:0]       id_rs, id_rt;
  logic [31:0]      rs_data, rt_data;
  logic [PC_W-1:0]  id_pc;
  logic [15:0]      id_imm;
  logic [25:0]      id_jidx;
  logic             ex_wr_en, ex_is_load, mem_is_load;
  logic [4:0]       ex_wr_reg, mem_wr_reg;
  logic             stall_id, flush_if_id, redirect_valid;
  logic [PC_W-1:0]  redirect_pc;
  logic [CNT_W-1:0] br_cnt, taken_cnt;

  int checks = 0;
  int passes = 0;

  // reference model: remaining wait cycles, counts, pending redirect
  int          m_wait;
  int          m_br, m_tk;
  logic        m_rv;
  logic [31:0] m_rpc;

  branch_ctrl #(.PC_W(PC_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_br_op(id_br_op),
    .id_rs(id_rs), .id_rt(id_rt), .rs_data(rs_data), .rt_data(rt_data),
    .id_pc(id_pc), .id_imm(id_imm), .id_jidx(id_jidx),
    .ex_wr_en(ex_wr_en), .ex_wr_reg(ex_wr_reg), .ex_is_load(ex_is_load),
    .mem_wr_reg(mem_wr_reg), .mem_is_load(mem_is_load),
    .stall_id(stall_id), .flush_if_id(flush_if_id), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .br_cnt(br_cnt), .taken_cnt(taken_cnt)
  );

  always #5 clk = ~clk;

  function automatic bit m_is_br();
    return id_valid && (id_br_op >= 4'd1) && (id_br_op <= 4'd8);
  endfunction

  function automatic int m_hz_cycles();
    bit urs, urt, exh, memh;
    urs  = (id_br_op inside {4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd8}) && id_rs != 5'd0;
    urt  = (id_br_op inside {4'd1, 4'd2}) && id_rt != 5'd0;
    exh  = ex_wr_en && ((urs && id_rs == ex_wr_reg) || (urt && id_rt == ex_wr_reg));
    memh = mem_is_load && ((urs && id_rs == mem_wr_reg) || (urt && id_rt == mem_wr_reg));
    if (exh && ex_is_load) return 2;
    if (exh || memh) return 1;
    return 0;
  endfunction

  function automatic bit m_taken();
    int a, b;
    a = $signed(rs_data);
    b = $signed(rt_data);
    case (id_br_op)
      4'd1: return a == b;
      4'd2: return a != b;
      4'd3: return a <= 0;
      4'd4: return a > 0;
      4'd5: return a < 0;
      4'd6: return a >= 0;
      4'd7, 4'd8: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [31:0] m_target();
    int off;
    off = $signed(id_imm);
    if (id_br_op == 4'd7) return ((id_pc + 32'd4) & 32'hF000_0000) | (32'(id_jidx) * 32'd4);
    if (id_br_op == 4'd8) return rs_data;
    return id_pc + 32'd4 + 32'(off * 4);
  endfunction

  function automatic bit m_stall();
    return (m_wait > 0) || (m_is_br() && m_hz_cycles() > 0);
  endfunction

  // advance the model across one clock edge using the current inputs
  function automatic void m_edge();
    logic        nrv;
    logic [31:0] nrpc;
    nrv = 1'b0;
    nrpc = 32'd0;
    if (m_wait > 0) begin
      m_wait--;
    end else if (m_is_br()) begin
      if (m_hz_cycles() > 0) begin
        m_wait = m_hz_cycles();
      end else begin
        if (m_br < CMAX) m_br++;
        if (m_taken()) begin
          if (m_tk < CMAX) m_tk++;
          nrv = 1'b1;
          nrpc = m_target();
        end
      end
    end
    m_rv = nrv;
    m_rpc = nrpc;
  endfunction

  task automatic set_idle();
    id_valid = 1'b0; id_br_op = 4'd0; id_rs = 5'd0; id_rt = 5'd0;
    rs_data = 32'd0; rt_data = 32'd0; id_pc = 32'd0; id_imm = 16'd0; id_jidx = 26'd0;
    ex_wr_en = 1'b0; ex_wr_reg = 5'd0; ex_is_load = 1'b0;
    mem_wr_reg = 5'd0; mem_is_load = 1'b0;
  endtask

  task automatic drive_br(input logic [3:0] op, input logic [4:0] rs, input logic [4:0] rt,
                          input logic [31:0] rsd, input logic [31:0] rtd,
                          input logic [31:0] pc, input logic [15:0] imm, input logic [25:0] jidx);
    set_idle();
    id_valid = 1'b1; id_br_op = op; id_rs = rs; id_rt = rt;
    rs_data = rsd; rt_data = rtd; id_pc = pc; id_imm = imm; id_jidx = jidx;
  endtask

  // leaves the bench at posedge+1 with reset released and the model cleared
  task automatic do_reset();
    set_idle();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    m_wait = 0; m_br = 0; m_tk = 0; m_rv = 1'b0; m_rpc = 32'd0;
  endtask

  task automatic test_reset();
    set_idle();
    rst = 1'b1;
    @(posedge clk); #1;
    checks++; if (stall_id !== 1'b0) $display("FAIL reset_stall: got %b want 0", stall_id); else passes++;
    checks++; if (redirect_valid !== 1'b0) $display("FAIL reset_rv: got %b want 0", redirect_valid); else passes++;
    checks++; if (flush_if_id !== 1'b0) $display("FAIL reset_flush: got %b want 0", flush_if_id); else passes++;
    checks++; if (redirect_pc !== 32'd0) $display("FAIL reset_rpc: got %h want 0", redirect_pc); else passes++;
    checks++; if (br_cnt !== 4'd0) $display("FAIL reset_br: got %0d want 0", br_cnt); else passes++;
    checks++; if (taken_cnt !== 4'd0) $display("FAIL reset_tk: got %0d want 0", taken_cnt); else passes++;
  endtask

  task automatic test_beq_bgtz();
    do_reset();
    drive_br(4'd1, 5'd5, 5'd6, 32'd5, 32'd5, 32'h100, 16'h0004, 26'd0);
    #1;
    checks++; if (stall_id !== 1'b0) $display("FAIL beq_stall: got %b want 0", stall_id); else passes++;
    @(posedge clk); #1;
    set_idle();
    checks++; if (redirect_valid !== 1'b1) $display("FAIL beq_rv: got %b want 1", redirect_valid); else passes++;
    checks++; if (redirect_pc !== 32'h114) $display("FAIL beq_rpc: got %h want 114", redirect_pc); else passes++;
    checks++; if (flush_if_id !== 1'b1) $display("FAIL beq_flush: got %b want 1", flush_if_id); else passes++;
    checks++; if (br_cnt !== 4'd1 || taken_cnt !== 4'd1) $display("FAIL beq_cnt: got %0d/%0d want 1/1", br_cnt, taken_cnt); else passes++;
    @(posedge clk); #1;
    checks++; if (redirect_valid !== 1'b0 || flush_if_id !== 1'b0) $display("FAIL beq_pulse: got %b%b want 00", redirect_valid, flush_if_id); else passes++;
    // BGTZ with rs = -1 is never taken
    do_reset();
    drive_br(4'd4, 5'd3, 5'd0, 32'hFFFF_FFFF, 32'd0, 32'h200, 16'h0004, 26'd0);
    @(posedge clk); #1;
    set_idle();
    checks++; if (redirect_valid !== 1'b0) $display("FAIL bgtz_rv: got %b want 0", redirect_valid); else passes++;
    checks++; if (br_cnt !== 4'd1 || taken_cnt !== 4'd0) $display("FAIL bgtz_cnt: got %0d/%0d want 1/0", br_cnt, taken_cnt); else passes++;
  endtask

  task automatic test_load_ex_stall();
    int n;
    do_reset();
    drive_br(4'd2, 5'd8, 5'd3, 32'd1, 32'd2, 32'h200, 16'hFFFC, 26'd0);
    ex_wr_en = 1'b1; ex_wr_reg = 5'd8; ex_is_load = 1'b1;
    n = 0;
    #1;
    while (stall_id === 1'b1 && n < 10) begin
      n++;
      @(posedge clk); #1;
      ex_wr_en = 1'b0;
      #1;
    end
    checks++; if (n != 3) $display("FAIL loadex_stall_cycles: got %0d want 3", n); else passes++;
    @(posedge clk); #1;
    set_idle();
    checks++; if (redirect_valid !== 1'b1) $display("FAIL loadex_rv: got %b want 1", redirect_valid); else passes++;
    checks++; if (redirect_pc !== 32'h1F4) $display("FAIL loadex_rpc: got %h want 1f4", redirect_pc); else passes++;
    checks++; if (br_cnt !== 4'd1) $display("FAIL loadex_br: got %0d want 1", br_cnt); else passes++;
  endtask

  task automatic test_jr();
    int n;
    do_reset();
    drive_br(4'd8, 5'd9, 5'd9, 32'h0040_0020, 32'd0, 32'h300, 16'd0, 26'd0);
    ex_wr_en = 1'b1; ex_wr_reg = 5'd9; ex_is_load = 1'b0;
    n = 0;
    #1;
    while (stall_id === 1'b1 && n < 10) begin
      n++;
      @(posedge clk); #1;
      ex_wr_en = 1'b0;
      #1;
    end
    checks++; if (n != 2) $display("FAIL jr_stall_cycles: got %0d want 2", n); else passes++;
    @(posedge clk); #1;
    checks++; if (redirect_valid !== 1'b1 || redirect_pc !== 32'h0040_0020) $display("FAIL jr_rpc: got %b/%h want 1/00400020", redirect_valid, redirect_pc); else passes++;
    // r0 as source and destination is never a hazard
    drive_br(4'd8, 5'd0, 5'd0, 32'h0000_1000, 32'd0, 32'h400, 16'd0, 26'd0);
    ex_wr_en = 1'b1; ex_wr_reg = 5'd0; ex_is_load = 1'b1;
    #1;
    checks++; if (stall_id !== 1'b0) $display("FAIL jr_r0_stall: got %b want 0", stall_id); else passes++;
    @(posedge clk); #1;
    set_idle();
    checks++; if (redirect_pc !== 32'h0000_1000 || br_cnt !== 4'd2) $display("FAIL jr_r0_rpc: got %h/%0d want 00001000/2", redirect_pc, br_cnt); else passes++;
  endtask

  task automatic test_back_to_back();
    do_reset();
    drive_br(4'd7, 5'd0, 5'd0, 32'd0, 32'd0, 32'h8000_0010, 16'd0, 26'h0000040);
    #1;
    checks++; if (stall_id !== 1'b0) $display("FAIL j_stall: got %b want 0", stall_id); else passes++;
    @(posedge clk); #1;
    checks++; if (redirect_valid !== 1'b1 || redirect_pc !== 32'h8000_0100) $display("FAIL j_rpc: got %b/%h want 1/80000100", redirect_valid, redirect_pc); else passes++;
    // delay-slot branch arrives while the J redirect is on the wire
    drive_br(4'd1, 5'd4, 5'd5, 32'd7, 32'd7, 32'h8000_0014, 16'h0001, 26'd0);
    #1;
    checks++; if (stall_id !== 1'b0) $display("FAIL slot_stall: got %b want 0", stall_id); else passes++;
    @(posedge clk); #1;
    set_idle();
    checks++; if (redirect_valid !== 1'b1 || redirect_pc !== 32'h8000_001C) $display("FAIL slot_rpc: got %b/%h want 1/8000001c", redirect_valid, redirect_pc); else passes++;
    checks++; if (br_cnt !== 4'd2 || taken_cnt !== 4'd2) $display("FAIL slot_cnt: got %0d/%0d want 2/2", br_cnt, taken_cnt); else passes++;
  endtask

  task automatic test_reset_mid_stall();
    do_reset();
    drive_br(4'd2, 5'd8, 5'd3, 32'd1, 32'd2, 32'h500, 16'h0010, 26'd0);
    ex_wr_en = 1'b1; ex_wr_reg = 5'd8; ex_is_load = 1'b1;
    @(posedge clk); #1;
    ex_wr_en = 1'b0;
    #2;
    checks++; if (stall_id !== 1'b1) $display("FAIL mid_wait2_stall: got %b want 1", stall_id); else passes++;
    rst = 1'b1;
    #1;
    checks++; if ({stall_id, redirect_valid, flush_if_id} !== 3'b000 || redirect_pc !== 32'd0) $display("FAIL mid_rst_outs: got %b%b%b/%h want 000/0", stall_id, redirect_valid, flush_if_id, redirect_pc); else passes++;
    id_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      checks++; if (redirect_valid !== 1'b0 || br_cnt !== 4'd0) $display("FAIL mid_after_release: got %b/%0d want 0/0", redirect_valid, br_cnt); else passes++;
    end
  endtask

  task automatic test_saturation();
    int e;
    do_reset();
    for (int i = 0; i < 18; i++) begin
      drive_br(4'd7, 5'd0, 5'd0, 32'd0, 32'd0, 32'(i) * 32'd16, 16'd0, 26'(i));
      @(posedge clk); #1;
      e = (i + 1 < CMAX) ? i + 1 : CMAX;
      checks++; if (br_cnt !== 4'(e) || taken_cnt !== 4'(e)) $display("FAIL sat_cnt[%0d]: got %0d/%0d want %0d/%0d", i, br_cnt, taken_cnt, e, e); else passes++;
    end
    set_idle();
  endtask

  task automatic test_random();
    bit es;
    do_reset();
    for (int i = 0; i < 600; i++) begin
      set_idle();
      id_valid    = ($urandom_range(0, 4) != 0);
      id_br_op    = 4'($urandom_range(0, 8));
      id_rs       = 5'($urandom_range(0, 3));
      id_rt       = 5'($urandom_range(0, 3));
      case ($urandom_range(0, 3))
        0: rs_data = 32'd0;
        1: rs_data = 32'hFFFF_FFFF;
        2: rs_data = 32'd1;
        default: rs_data = $urandom;
      endcase
      rt_data     = ($urandom_range(0, 1) != 0) ? rs_data : $urandom;
      id_pc       = $urandom & 32'hFFFF_FFFC;
      id_imm      = 16'($urandom);
      id_jidx     = 26'($urandom);
      ex_wr_en    = ($urandom_range(0, 1) != 0);
      ex_wr_reg   = 5'($urandom_range(0, 3));
      ex_is_load  = ($urandom_range(0, 2) == 0);
      mem_wr_reg  = 5'($urandom_range(0, 3));
      mem_is_load = ($urandom_range(0, 2) == 0);
      #1;
      es = m_stall();
      checks++; if (stall_id !== es) $display("FAIL rnd_stall[%0d]: got %b want %b", i, stall_id, es); else passes++;
      m_edge();
      @(posedge clk); #1;
      checks++; if (redirect_valid !== m_rv || flush_if_id !== m_rv) $display("FAIL rnd_rv[%0d]: got %b%b want %b", i, redirect_valid, flush_if_id, m_rv); else passes++;
      checks++; if (redirect_pc !== m_rpc) $display("FAIL rnd_rpc[%0d]: got %h want %h", i, redirect_pc, m_rpc); else passes++;
      checks++; if (br_cnt !== 4'(m_br) || taken_cnt !== 4'(m_tk)) $display("FAIL rnd_cnt[%0d]: got %0d/%0d want %0d/%0d", i, br_cnt, taken_cnt, m_br, m_tk); else passes++;
    end
    set_idle();
  endtask

  initial begin
    set_idle();
    test_reset();
    test_beq_bgtz();
    test_load_ex_stall();
    test_jr();
    test_back_to_back();
    test_reset_mid_stall();
    test_saturation();
    test_random();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
